// File: rtl/semiauto_nav.sv
// Purpose: semi-automatic line-following car navigator (crossroad stop, operator-commanded turns, cooldown).
// Latency: every decision is visible on state/moving_state/lights one sys_clk after the deciding input cycle.
// Backpressure: none; commands are sampled only in WAIT and ignored elsewhere, timers advance only on tick.
module semiauto_nav #(
    parameter int TURN_TICKS = 80,
    parameter int COOL_TICKS = 50,
    parameter int CNT_W      = 8
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       power,
    input  logic [1:0] global_state,
    input  logic [3:0] detector,
    input  logic       turn_left,
    input  logic       turn_right,
    input  logic       go_straight,
    input  logic       go_back,
    output logic [1:0] state,
    output logic [3:0] moving_state,
    output logic       move_forward_light,
    output logic       move_backward_light,
    output logic       turn_left_light,
    output logic       turn_right_light
);

    typedef enum logic [1:0] {
        ST_FORWARD  = 2'b00,
        ST_WAIT     = 2'b01,
        ST_TURN     = 2'b10,
        ST_COOLDOWN = 2'b11
    } nav_state_t;

    localparam logic [3:0] MV_STOP       = 4'b0000;
    localparam logic [3:0] MV_FORWARD    = 4'b0001;
    localparam logic [3:0] MV_TURN_LEFT  = 4'b0100;
    localparam logic [3:0] MV_TURN_RIGHT = 4'b1000;

    // Terminal counts: the timer leaves its phase on the tick that finds it at LIMIT-1.
    localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_TICKS - 1);
    localparam logic [CNT_W-1:0] UTURN_LAST = CNT_W'(2 * TURN_TICKS - 1);
    localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOL_TICKS - 1);

    nav_state_t       state_q, state_d;
    logic [3:0]       mv_q, mv_d;
    logic [CNT_W-1:0] turn_cnt_q, turn_cnt_d;
    logic [CNT_W-1:0] cool_cnt_q, cool_cnt_d;
    logic             uturn_q, uturn_d;

    logic             crossroad;
    logic             enabled;
    logic             cmd_valid;
    logic [CNT_W-1:0] turn_last;
    logic             unused_detector_bit;

    // detector[3] is the obstacle sensor, not part of crossroad detection.
    assign unused_detector_bit = detector[3];

    assign crossroad = detector[0] | ~detector[1] | ~detector[2];
    assign enabled   = power & ((global_state == 2'b01) | (global_state == 2'b10));
    assign cmd_valid = $onehot({turn_left, turn_right, go_straight, go_back});
    // A U-turn is two back-to-back 90-degree turns to the right.
    assign turn_last = uturn_q ? UTURN_LAST : TURN_LAST;

    // Next-state, movement and timer logic; disabling forces the parked WAIT condition.
    always_comb begin
        state_d    = state_q;
        mv_d       = mv_q;
        turn_cnt_d = turn_cnt_q;
        cool_cnt_d = cool_cnt_q;
        uturn_d    = uturn_q;
        if (!enabled) begin
            state_d    = ST_WAIT;
            mv_d       = MV_STOP;
            turn_cnt_d = '0;
            cool_cnt_d = '0;
            uturn_d    = 1'b0;
        end else begin
            case (state_q)
                ST_FORWARD: begin
                    mv_d = MV_FORWARD;
                    if (crossroad) begin
                        state_d = ST_WAIT;
                        mv_d    = MV_STOP;
                    end
                end
                ST_WAIT: begin
                    mv_d = MV_STOP;
                    if (cmd_valid) begin
                        if (go_straight) begin
                            state_d    = ST_COOLDOWN;
                            mv_d       = MV_FORWARD;
                            cool_cnt_d = '0;
                        end else begin
                            state_d    = ST_TURN;
                            turn_cnt_d = '0;
                            if (turn_left) begin
                                mv_d = MV_TURN_LEFT;
                            end else begin
                                mv_d    = MV_TURN_RIGHT;
                                uturn_d = go_back;
                            end
                        end
                    end
                end
                ST_TURN: begin
                    if (tick) begin
                        if (turn_cnt_q == turn_last) begin
                            state_d    = ST_COOLDOWN;
                            mv_d       = MV_FORWARD;
                            uturn_d    = 1'b0;
                            cool_cnt_d = '0;
                        end else begin
                            turn_cnt_d = turn_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_COOLDOWN: begin
                    // Crossroad is deliberately ignored here so the car can clear the junction.
                    mv_d = MV_FORWARD;
                    if (tick) begin
                        if (cool_cnt_q == COOL_LAST) begin
                            state_d = ST_FORWARD;
                        end else begin
                            cool_cnt_d = cool_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_WAIT;
                    mv_d    = MV_STOP;
                end
            endcase
        end
    end

    // State, timers and lights register together so lights always match moving_state.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q             <= ST_WAIT;
            mv_q                <= MV_STOP;
            turn_cnt_q          <= '0;
            cool_cnt_q          <= '0;
            uturn_q             <= 1'b0;
            move_forward_light  <= 1'b0;
            move_backward_light <= 1'b0;
            turn_left_light     <= 1'b0;
            turn_right_light    <= 1'b0;
        end else begin
            state_q             <= state_d;
            mv_q                <= mv_d;
            turn_cnt_q          <= turn_cnt_d;
            cool_cnt_q          <= cool_cnt_d;
            uturn_q             <= uturn_d;
            move_forward_light  <= (mv_d == MV_FORWARD);
            move_backward_light <= uturn_d;
            turn_left_light     <= (mv_d == MV_TURN_LEFT);
            turn_right_light    <= (mv_d == MV_TURN_RIGHT);
        end
    end

    assign state        = state_q;
    assign moving_state = mv_q;

endmodule

// File: doc/semiauto_nav.md
SEMIAUTO_NAV -- requirements
Module: semiauto_nav

Interface
REQ-001 Parameter TURN_TICKS, default 80, sets the tick count of one 90-degree turn; legal range is at least 1.
REQ-002 Parameter COOL_TICKS, default 50, sets the tick count during which crossroad detection is ignored after leaving a crossroad; legal range is at least 1.
REQ-003 Parameter CNT_W, default 8, is the timer counter width; it SHALL satisfy 2^CNT_W >= 2*TURN_TICKS and 2^CNT_W >= COOL_TICKS.
REQ-004 sys_clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 rst, input, 1 bit: synchronous, active-high reset.
REQ-006 tick, input, 1 bit: one-sys_clk-wide timebase pulse; only the timers count on it.
REQ-007 power, input, 1 bit: high means the car is powered.
REQ-008 global_state, input, 2 bits: the block is enabled only for values 2'b01 and 2'b10.
REQ-009 detector, input, 4 bits: line and obstacle sensors.
REQ-010 turn_left, turn_right, go_straight and go_back, inputs, 1 bit each: operator commands.
REQ-011 state, output, 2 bits, registered: FORWARD=00, WAIT=01, TURN=10, COOLDOWN=11.
REQ-012 moving_state, output, 4 bits, registered: STOP=0000, MOVE_FORWARD=0001, TURN_LEFT=0100, TURN_RIGHT=1000.
REQ-013 move_forward_light, move_backward_light, turn_left_light and turn_right_light, outputs, 1 bit each, registered.

Function
REQ-014 crossroad SHALL be detector[0] OR NOT detector[1] OR NOT detector[2], and SHALL be evaluated combinationally each cycle.
REQ-015 A command SHALL be valid only when exactly one of the four command inputs is high; zero or multiple high inputs SHALL be treated as no command.
REQ-016 enabled SHALL be power AND (global_state == 01 OR global_state == 10).
REQ-017 While enabled is low, the next cycle SHALL be: state=WAIT, moving_state=STOP, all lights 0, counters 0, U-turn flag 0.
REQ-018 In FORWARD (moving_state MOVE_FORWARD): if crossroad is high, the next state SHALL be WAIT with STOP; otherwise the block SHALL stay in FORWARD.
REQ-019 In WAIT (STOP), transitions SHALL be:
- go_straight -> COOLDOWN with MOVE_FORWARD;
- turn_left -> TURN with TURN_LEFT;
- turn_right -> TURN with TURN_RIGHT;
- go_back -> TURN with TURN_RIGHT and the U-turn flag set;
- no valid command -> stay in WAIT.
REQ-020 On entry to TURN or COOLDOWN, the turn counter or cool counter SHALL be cleared to 0.
REQ-021 In TURN, the turn counter SHALL increment by 1 only on cycles with tick high.
REQ-022 TURN SHALL exit on the tick where the turn counter equals LIMIT-1, going to COOLDOWN with MOVE_FORWARD and clearing the U-turn flag.
- LIMIT = TURN_TICKS normally.
- LIMIT = 2*TURN_TICKS when the U-turn flag is set.
REQ-023 In COOLDOWN (MOVE_FORWARD), crossroad SHALL be ignored and the cool counter SHALL increment on tick.
REQ-024 COOLDOWN SHALL exit on the tick where the cool counter equals COOL_TICKS-1, going to FORWARD.
REQ-025 Commands SHALL be ignored in every state except WAIT; timers SHALL hold their value on cycles with tick low.
REQ-026 Lights SHALL be registered in the same cycle as moving_state:
- move_forward_light = (moving_state == MOVE_FORWARD);
- turn_left_light = (moving_state == TURN_LEFT);
- turn_right_light = (moving_state == TURN_RIGHT);
- move_backward_light = U-turn flag.
REQ-027 Every state change SHALL appear on the outputs exactly one sys_clk after the deciding input cycle.

Reset
REQ-028 rst high at a sys_clk edge SHALL give: state=WAIT, moving_state=STOP, all lights 0, both counters 0, U-turn flag 0.
REQ-029 rst SHALL take priority over enabled, tick and all commands, including mid-TURN and mid-COOLDOWN.
REQ-030 After rst is released, the block SHALL stay in WAIT until a valid command arrives.

Verification (TURN_TICKS=4, COOL_TICKS=3, enabled, detector=4'b0110 unless stated)
REQ-031 Reset, then turn_left pulse -> TURN/0100 next cycle; after 4 ticks -> COOLDOWN/0001; after 3 more ticks -> FORWARD/0001, with turn_left_light high only during TURN.
REQ-032 go_back in WAIT -> TURN/1000 with move_backward_light=1 for exactly 8 ticks, then COOLDOWN/0001 with move_backward_light=0.
REQ-033 In FORWARD, set detector=4'b0100 -> WAIT/0000 next cycle; repeat in COOLDOWN -> no state change.
REQ-034 In WAIT, assert turn_left and turn_right together -> stays WAIT/0000; then go_straight alone -> COOLDOWN/0001.
REQ-035 Mid-TURN (2 ticks in), either drop power or assert rst -> WAIT/0000 with lights 0 next cycle; a later turn_right restarts the full 4-tick turn.
REQ-036 In TURN with tick held low for 20 cycles -> the turn counter stays constant and the block stays in TURN.
